alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Upstream feeder for the 8-bit ALU.
- Accepts operation commands {A, B, op} over a valid/ready handshake and buffers them in a small FIFO.
- Issues commands one at a time as the ALU's packed input, one-cycle valid pulse and op code, then waits for the ALU's ready.
- Returns each result over a valid/ready result handshake; screens divide-by-zero before issue.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit; only used when ALU_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a clk edge.
- cmd_a  input  8  operand A.
- cmd_b  input  8  operand B.
- cmd_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- alu_in  output  16  packed {A, B} to the ALU; A in [15:8], B in [7:0].
- alu_op_codes  output  2  op code to the ALU.
- alu_valid  output  1  one-cycle issue pulse to the ALU.
- alu_o  input  8  ALU result.
- alu_ready  input  1  ALU result valid on alu_o.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  8  result byte.
- res_op  output  2  op code of the returned result.
- res_err  output  1  result is an error substitute, not an ALU result.
- busy  output  1  high when state is not IDLE or the FIFO is non-empty.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied, pointers 0, count 0, state IDLE.
  - cmd_ready=1; all other outputs 0: alu_in, alu_op_codes, alu_valid, res_valid, res_data, res_op, res_err, busy.
  - Any in-flight operation is discarded.
- FIFO:
  - cmd_ready = (count != DEPTH).
  - Push on cmd_valid & cmd_ready; pop only from IDLE.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - No bypass: a pushed entry is visible to IDLE from the next cycle.
- FSM states:
  - IDLE: if count>0, pop the head at the next edge.
    - If op=11 and B=0: go to HOLD with res_data=8'hFF, res_err=1, res_op=11; no ALU issue.
    - Otherwise: load alu_in={A,B} and alu_op_codes=op, go to ISSUE.
  - ISSUE: alu_valid=1 for exactly this one cycle; next state WAIT. alu_ready is ignored in ISSUE.
  - WAIT: alu_valid=0; alu_in and alu_op_codes stay stable. On the first edge with alu_ready=1, capture res_data=alu_o, res_err=0, res_op=op, then go to HOLD.
  - HOLD: res_valid=1; res_data, res_op and res_err are stable. On res_ready=1, go to IDLE and deassert res_valid at that edge.
- Latency:
  - Command accepted at edge k into an empty FIFO with state IDLE gives alu_valid high in cycle k+1 to k+2.
  - alu_ready seen at edge m gives res_valid high from edge m.
  - Back-to-back minimum: res_ready at edge h, then next alu_valid in cycle h+1 to h+2.
- Ignored inputs: alu_ready is ignored outside WAIT. cmd inputs are ignored when cmd_ready=0.
- Width rules: res_data is the 8-bit ALU output, passed unmodified. No sign handling in this block.
- Reset asserted mid-WAIT or mid-HOLD: result lost, no res_valid after release, FIFO empty.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no alu_ready: go to HOLD with res_data=8'h00, res_err=1, res_op=op.
  - alu_ready in the same cycle as expiry wins and gives a normal result.
- Undefined: WAIT holds indefinitely; no counter logic exists; TIMEOUT_CYCLES is unused.

Test Plan:
- Basic ops, one at a time with res_ready=1 and a real ALU:
  - ADD {25,17} -> res_data 42.
  - SUB {40,15} -> 25.
  - MUL {5,3} -> 15.
  - DIV {20,4} -> 5.
  - Each: res_err=0, exactly one alu_valid pulse, alu_in 16'h1911 for the ADD.
- Divide by zero: DIV {9,0} -> res_data 8'hFF, res_err=1, res_op=11, alu_valid never asserted.
- FIFO fill:
  - Hold res_ready=0 and push 6 commands back to back.
  - Required: 1 popped into flight, count reaches 4, cmd_ready=0 afterwards.
  - Release res_ready: all 5 accepted results return in push order, no loss or duplication, count returns to 0 with pointer wrap exercised.
- Result backpressure: res_ready=0 for 20 cycles in HOLD -> res_valid, res_data and res_op stable; no new alu_valid.
- Timeout (ALU_TIMEOUT_EN, TIMEOUT_CYCLES=64, stub ALU never ready): ADD {1,2} -> res_valid exactly 64 WAIT cycles after ISSUE, res_data 0, res_err=1. Macro undefined -> res_valid stays 0 for at least 200 cycles.
- Reset mid-operation: assert rst=0 during WAIT with 2 commands queued -> alu_valid, res_valid, count and busy 0 immediately (async); no result emitted after release.

Source files
------------

// File: rtl/alu_cmd_issuer_if.sv
// Handshake bundle between the command source, alu_cmd_issuer, the 8-bit ALU and the result consumer.
// master = surrounding environment, slave = alu_cmd_issuer.
interface alu_cmd_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [1:0]  cmd_op;
  logic [15:0] alu_in;
  logic [1:0]  alu_op_codes;
  logic        alu_valid;
  logic [7:0]  alu_o;
  logic        alu_ready;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [1:0]  res_op;
  logic        res_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_o, alu_ready, res_ready,
    input  cmd_ready, alu_in, alu_op_codes, alu_valid, res_valid, res_data, res_op, res_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_o, alu_ready, res_ready,
    output cmd_ready, alu_in, alu_op_codes, alu_valid, res_valid, res_data, res_op, res_err
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Command FIFO plus single-outstanding issue FSM feeding the 8-bit ALU, with divide-by-zero screening.
// Optional WAIT-state timeout enabled by defining ALU_TIMEOUT_EN.
module alu_cmd_issuer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_cmd_issuer_if.slave        bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int DATA_W  = 8;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * DATA_W + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_cmd_issuer: DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("alu_cmd_issuer: TIMEOUT_CYCLES must be at least 1");
  end

  function automatic logic is_div_zero(input logic [1:0] op, input logic [DATA_W-1:0] b);
    return (op == 2'b11) && (b == '0);
  endfunction

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [2*DATA_W-1:0]   alu_in_q, alu_in_d;
  logic [1:0]            alu_op_q, alu_op_d;
  logic                  alu_valid_q, alu_valid_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_W-1:0]     res_data_q, res_data_d;
  logic [1:0]            res_op_q, res_op_d;
  logic                  res_err_q, res_err_d;
  logic [ENTRY_W-1:0]    fifo_q [DEPTH];

`ifdef ALU_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
`endif

  logic                  push, pop;
  logic [ENTRY_W-1:0]    head;
  logic [1:0]            head_op;
  logic [DATA_W-1:0]     head_a, head_b;

  assign bus.cmd_ready = (count_q != CNT_W'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state_q == IDLE) && (count_q != '0);
  assign head          = fifo_q[rd_ptr_q];
  assign head_op       = head[ENTRY_W-1 -: 2];
  assign head_a        = head[2*DATA_W-1 -: DATA_W];
  assign head_b        = head[DATA_W-1:0];

  // Storage holds only data, so it carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    alu_in_d    = alu_in_q;
    alu_op_d    = alu_op_q;
    alu_valid_d = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
`ifdef ALU_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          if (is_div_zero(head_op, head_b)) begin
            state_d     = HOLD;
            res_valid_d = 1'b1;
            res_data_d  = 8'hFF;
            res_op_d    = 2'b11;
            res_err_d   = 1'b1;
          end else begin
            state_d     = ISSUE;
            alu_in_d    = {head_a, head_b};
            alu_op_d    = head_op;
            alu_valid_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef ALU_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      WAIT: begin
        // A result arriving on the expiry cycle takes precedence over the timeout.
        if (bus.alu_ready) begin
          state_d     = HOLD;
          res_valid_d = 1'b1;
          res_data_d  = bus.alu_o;
          res_op_d    = alu_op_q;
          res_err_d   = 1'b0;
        end
`ifdef ALU_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = HOLD;
          res_valid_d = 1'b1;
          res_data_d  = 8'h00;
          res_op_d    = alu_op_q;
          res_err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_in_q    <= '0;
      alu_op_q    <= '0;
      alu_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_in_q    <= alu_in_d;
      alu_op_q    <= alu_op_d;
      alu_valid_q <= alu_valid_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
`ifdef ALU_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign bus.alu_in       = alu_in_q;
  assign bus.alu_op_codes = alu_op_q;
  assign bus.alu_valid    = alu_valid_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_op       = res_op_q;
  assign bus.res_err      = res_err_q;
  assign busy             = (state_q != IDLE) || (count_q != '0);
  assign count            = count_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: behavioural ALU responder plus hand-computed expected results.
module tb_alu_cmd_issuer;
  logic       clk;
  logic       rst;
  logic       busy;
  logic [2:0] count;

  alu_cmd_issuer_if bus();

  alu_cmd_issuer #(.DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .count (count)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          pulses_total = 0;
  logic [15:0] last_alu_in = '0;
  bit          alu_en;
  int          base, n_acc, got, extra, n, n_rv;
  bit          stable;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] exp;
    logic       err;
  } vec_t;

  vec_t basic [5] = '{
    '{8'd25, 8'd17, 2'b00, 8'd42,  1'b0},
    '{8'd40, 8'd15, 2'b01, 8'd25,  1'b0},
    '{8'd5,  8'd3,  2'b10, 8'd15,  1'b0},
    '{8'd20, 8'd4,  2'b11, 8'd5,   1'b0},
    '{8'd9,  8'd0,  2'b11, 8'hFF,  1'b1}
  };

  // Sixth entry is offered while the FIFO is full and must be dropped.
  vec_t fill [6] = '{
    '{8'd10,  8'd1,   2'b00, 8'd11,  1'b0},
    '{8'd50,  8'd8,   2'b01, 8'd42,  1'b0},
    '{8'd7,   8'd7,   2'b10, 8'd49,  1'b0},
    '{8'd100, 8'd100, 2'b00, 8'd200, 1'b0},
    '{8'd3,   8'd5,   2'b01, 8'hFE,  1'b0},
    '{8'd1,   8'd1,   2'b00, 8'd2,   1'b0}
  };

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (bus.alu_valid === 1'b1) begin
      pulses_total <= pulses_total + 1;
      last_alu_in  <= bus.alu_in;
    end
  end

  function automatic logic [7:0] alu_model(input logic [15:0] ab, input logic [1:0] op);
    logic [7:0]  a, b;
    logic [15:0] p;
    a = ab[15:8];
    b = ab[7:0];
    p = a * b;
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return p[7:0];
      default: return (b == 8'd0) ? 8'hFF : a / b;
    endcase
  endfunction

  // Behavioural ALU: answers two cycles after each issue pulse while alu_en is set.
  initial begin : alu_responder
    logic [7:0] r;
    bus.alu_ready = 1'b0;
    bus.alu_o     = 8'd0;
    forever begin
      @(negedge clk);
      bus.alu_ready = 1'b0;
      if (bus.alu_valid === 1'b1 && alu_en) begin
        r = alu_model(bus.alu_in, bus.alu_op_codes);
        repeat (2) @(negedge clk);
        bus.alu_o     = r;
        bus.alu_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int limit);
    for (int i = 0; i < limit && bus.res_valid !== 1'b1; i++) @(negedge clk);
    chk({tag, "_res_valid"}, bus.res_valid, 1);
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int b0;
    b0 = pulses_total;
    send(v.a, v.b, v.op);
    @(negedge clk);
    if (!v.err) chk({tag, "_issue_lat"}, bus.alu_valid, 1);
    wait_res(tag, 50);
    chk({tag, "_data"}, bus.res_data, v.exp);
    chk({tag, "_err"},  bus.res_err, v.err);
    chk({tag, "_op"},   bus.res_op, v.op);
    repeat (3) @(negedge clk);
    chk({tag, "_pulses"}, pulses_total - b0, v.err ? 0 : 1);
    chk({tag, "_busy"},   busy, 0);
  endtask

  initial begin
    rst           = 1'b0;
    alu_en        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'd0;
    bus.cmd_b     = 8'd0;
    bus.cmd_op    = 2'b00;
    bus.res_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_alu_valid", bus.alu_valid, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_alu_in",    bus.alu_in, 0);
    chk("rst_res_data",  bus.res_data, 0);
    chk("rst_res_err",   bus.res_err, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_count",     count, 0);
    rst = 1'b1;
    @(negedge clk);

    // One operation at a time, consumer always ready.
    bus.res_ready = 1'b1;
    run_op("add", basic[0]);
    chk("add_alu_in", last_alu_in, 16'h1911);
    run_op("sub",  basic[1]);
    run_op("mul",  basic[2]);
    run_op("div",  basic[3]);
    run_op("div0", basic[4]);

    // Fill the FIFO while the first result is held.
    bus.res_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = fill[i].a;
      bus.cmd_b     = fill[i].b;
      bus.cmd_op    = fill[i].op;
      if (bus.cmd_ready === 1'b1) n_acc++;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    chk("fill_accepted", n_acc, 5);
    repeat (6) @(negedge clk);
    chk("fill_count",     count, 4);
    chk("fill_cmd_ready", bus.cmd_ready, 0);
    chk("fill_hold_data", bus.res_data, fill[0].exp);
    bus.res_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && got < 5; i++) begin
      if (bus.res_valid === 1'b1) begin
        chk($sformatf("fill_res%0d", got), bus.res_data, fill[got].exp);
        got++;
      end
      @(negedge clk);
    end
    chk("fill_res_count", got, 5);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.res_valid === 1'b1) extra++;
      @(negedge clk);
    end
    chk("fill_no_dup",     extra, 0);
    chk("fill_count_end",  count, 0);
    chk("fill_busy_end",   busy, 0);

    // Result backpressure with a second command queued behind it.
    bus.res_ready = 1'b0;
    send(8'd12, 8'd10, 2'b10);
    wait_res("bp", 50);
    chk("bp_data", bus.res_data, 8'd120);
    send(8'd2, 8'd2, 2'b00);
    base   = pulses_total;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_data !== 8'd120 || bus.res_op !== 2'b10) stable = 1'b0;
    end
    chk("bp_stable",    stable, 1);
    chk("bp_no_issue",  pulses_total - base, 0);
    chk("bp_count",     count, 1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", bus.res_valid, 0);
    wait_res("bp2", 50);
    chk("bp2_data", bus.res_data, 8'd4);
    repeat (3) @(negedge clk);

    // ALU that never answers.
    alu_en        = 1'b0;
    bus.res_ready = 1'b0;
    send(8'd1, 8'd2, 2'b00);
`ifdef ALU_TIMEOUT_EN
    for (int i = 0; i < 10 && bus.alu_valid !== 1'b1; i++) @(negedge clk);
    chk("tmo_issue", bus.alu_valid, 1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) break;
      n++;
    end
    chk("tmo_wait_cycles", n, 64);
    chk("tmo_res_valid",   bus.res_valid, 1);
    chk("tmo_data",        bus.res_data, 8'h00);
    chk("tmo_err",         bus.res_err, 1);
    chk("tmo_op",          bus.res_op, 2'b00);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    send(8'd3, 8'd4, 2'b00);
    send(8'd5, 8'd6, 2'b00);
    send(8'd7, 8'd8, 2'b00);
    repeat (5) @(negedge clk);
`else
    n_rv = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) n_rv++;
    end
    chk("notmo_no_result", n_rv, 0);
    chk("notmo_busy",      busy, 1);
    send(8'd5, 8'd6, 2'b00);
    send(8'd7, 8'd8, 2'b00);
    repeat (2) @(negedge clk);
`endif
    chk("prerst_count", count, 2);

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_alu_valid", bus.alu_valid, 0);
    chk("arst_res_valid", bus.res_valid, 0);
    chk("arst_count",     count, 0);
    chk("arst_busy",      busy, 0);
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    rst    = 1'b1;
    alu_en = 1'b1;
    bus.res_ready = 1'b1;
    base = pulses_total;
    n_rv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) n_rv++;
    end
    chk("postrst_no_result", n_rv, 0);
    chk("postrst_no_issue",  pulses_total - base, 0);
    chk("postrst_count",     count, 0);

    run_op("recover", basic[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
